// File: rtl/p1v_board_io.sv
`default_nettype none
// ============================================================================
// Module      : p1v_board_io
// Description : Board I/O conditioner sitting between a board top level and
//               the p1v core. It synchronises pad inputs, registers pad
//               drive/enable, produces a clean core reset from the global
//               reset and a board reset request, and drives cog-activity LEDs
//               with pulse stretching and selectable polarity.
//
// Ports
//   clock_160  in   1     sole clock
//   inp_resn   in   1     asynchronous active-low reset for every flop here
//   brd_resn   in   1     board reset request, active-low, asynchronous
//   pad_in     in   PINS  raw pad levels
//   pin_in     out  PINS  synchronised pad levels to the core
//   pin_out    in   PINS  core output levels
//   pin_dir    in   PINS  core direction, 1 = drive
//   pad_out    out  PINS  registered drive level
//   pad_oe     out  PINS  registered output enable (tristate where 0)
//   core_resn  out  1     reset to the core, active-low
//   cogled     in   LEDS  cog active flags (already in clock_160 domain)
//   led_act    out  LEDS  lit while cog active (stretched)
//   led_idle   out  LEDS  lit while cog inactive
//
// Revision    : 1.0  initial release
// ============================================================================
module p1v_board_io #(
    parameter int PINS           = 32,   // number of I/O pins handled
    parameter int SYNC_STAGES    = 2,    // synchroniser depth, must be >= 2
    parameter int LEDS           = 8,    // number of cog LED channels
    parameter int LED_ACTIVE_LOW = 1,    // 1 = LED lit when driven 0
    parameter int STRETCH_BITS   = 20,   // stretch length 2^STRETCH_BITS cycles
    parameter int RESET_HOLD     = 1024  // core reset hold-off in cycles, >= 1
) (
    input  logic            clock_160,
    input  logic            inp_resn,
    input  logic            brd_resn,
    input  logic [PINS-1:0] pad_in,
    output logic [PINS-1:0] pin_in,
    input  logic [PINS-1:0] pin_out,
    input  logic [PINS-1:0] pin_dir,
    output logic [PINS-1:0] pad_out,
    output logic [PINS-1:0] pad_oe,
    output logic            core_resn,
    input  logic [LEDS-1:0] cogled,
    output logic [LEDS-1:0] led_act,
    output logic [LEDS-1:0] led_idle
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    localparam int c_CNT_W = (RESET_HOLD > 1) ? $clog2(RESET_HOLD) : 1;
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(RESET_HOLD - 1);

    localparam logic [STRETCH_BITS-1:0] c_STRETCH_MAX = {STRETCH_BITS{1'b1}};
    localparam logic                    c_LED_POL     = (LED_ACTIVE_LOW != 0);

    // Reset sequencer states
    localparam logic [1:0] c_ST_HOLD   = 2'd0;  // counting down the hold-off
    localparam logic [1:0] c_ST_ASSERT = 2'd1;  // board request active
    localparam logic [1:0] c_ST_RUN    = 2'd2;  // core released

    // ------------------------------------------------------------------------
    // Input path: pad_in synchroniser chain, stage 0 samples the pad
    // ------------------------------------------------------------------------
    logic [SYNC_STAGES-1:0][PINS-1:0] r_pin_sync;

    always_ff @(posedge clock_160 or negedge inp_resn) begin
        if (!inp_resn) begin
            r_pin_sync <= '0;
        end else begin
            r_pin_sync <= {r_pin_sync[SYNC_STAGES-2:0], pad_in};
        end
    end

    assign pin_in = r_pin_sync[SYNC_STAGES-1];

    // ------------------------------------------------------------------------
    // Board reset request synchroniser. Resets to 1 so that a global reset
    // alone never looks like a board request.
    // ------------------------------------------------------------------------
    logic [SYNC_STAGES-1:0] r_brd_sync;
    logic                   w_brd_s;

    always_ff @(posedge clock_160 or negedge inp_resn) begin
        if (!inp_resn) begin
            r_brd_sync <= '1;
        end else begin
            r_brd_sync <= {r_brd_sync[SYNC_STAGES-2:0], brd_resn};
        end
    end

    assign w_brd_s = r_brd_sync[SYNC_STAGES-1];

    // ------------------------------------------------------------------------
    // Reset sequencer
    // ------------------------------------------------------------------------
    logic [1:0]         r_state;
    logic [1:0]         w_state_nxt;
    logic [c_CNT_W-1:0] r_cnt;
    logic [c_CNT_W-1:0] w_cnt_nxt;
    logic               r_core_resn;

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            c_ST_HOLD: begin
                // A fresh request outranks the release so the hold-off is
                // never credited across a request.
                if (!w_brd_s) begin
                    w_state_nxt = c_ST_ASSERT;
                end else if (r_cnt == c_CNT_LAST) begin
                    w_state_nxt = c_ST_RUN;
                end else begin
                    w_cnt_nxt = r_cnt + c_CNT_W'(1);
                end
            end
            c_ST_ASSERT: begin
                if (w_brd_s) begin
                    w_state_nxt = c_ST_HOLD;
                    w_cnt_nxt   = '0;
                end
            end
            c_ST_RUN: begin
                if (!w_brd_s) begin
                    w_state_nxt = c_ST_ASSERT;
                end
            end
            default: begin
                w_state_nxt = c_ST_HOLD;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    // core_resn is loaded from the next state so it is a clean flop output
    // that is high exactly while the sequencer sits in RUN.
    always_ff @(posedge clock_160 or negedge inp_resn) begin
        if (!inp_resn) begin
            r_state     <= c_ST_HOLD;
            r_cnt       <= '0;
            r_core_resn <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_core_resn <= (w_state_nxt == c_ST_RUN);
        end
    end

    assign core_resn = r_core_resn;

    // ------------------------------------------------------------------------
    // Output path. The enable is gated by the registered core reset, so the
    // pads float whenever the core is held in reset.
    // ------------------------------------------------------------------------
    logic [PINS-1:0] r_pad_out;
    logic [PINS-1:0] r_pad_oe;

    always_ff @(posedge clock_160 or negedge inp_resn) begin
        if (!inp_resn) begin
            r_pad_out <= '0;
            r_pad_oe  <= '0;
        end else begin
            r_pad_out <= pin_out;
            r_pad_oe  <= r_core_resn ? pin_dir : '0;
        end
    end

    assign pad_out = r_pad_out;
    assign pad_oe  = r_pad_oe;

    // ------------------------------------------------------------------------
    // LED pulse stretchers, one per cog channel
    // ------------------------------------------------------------------------
    logic [LEDS-1:0] w_lit;

    generate
        for (genvar i = 0; i < LEDS; i++) begin : g_led
            logic [STRETCH_BITS-1:0] r_stretch;
            logic                    r_lit;

            always_ff @(posedge clock_160 or negedge inp_resn) begin
                if (!inp_resn) begin
                    r_stretch <= '0;
                    r_lit     <= 1'b0;
                end else begin
                    // Reload wins over decrement when the cog re-activates.
                    if (cogled[i]) begin
                        r_stretch <= c_STRETCH_MAX;
                    end else if (r_stretch != '0) begin
                        r_stretch <= r_stretch - STRETCH_BITS'(1);
                    end
                    // Uses the count before this edge's update.
                    r_lit <= cogled[i] | (r_stretch != '0);
                end
            end

            assign w_lit[i] = r_lit;
        end
    endgenerate

    assign led_act  = w_lit ^ {LEDS{c_LED_POL}};
    assign led_idle = ~led_act;

endmodule

`default_nettype wire
